// File: rtl/tc_bank.sv
// tc_bank: NUM_CH independent down-counting timers behind one word-addressed register window.
// Optional macro TC_PRESCALE_EN adds a per-channel 16-bit prescaler at offset 3 bits[31:16].
module tc_bank #(
   parameter int          NUM_CH    = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
   parameter int          CNT_W     = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [29:0]       Addr,
   input  logic              WE,
   input  logic [31:0]       Din,
   output logic [31:0]       Dout,
   output logic [NUM_CH-1:0] IRQ
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

   logic [31:0] w_off;
   logic        w_hit;
   logic [2:0]  w_ch;
   logic [1:0]  w_reg;
   logic [31:0] w_chRd [NUM_CH];

   // Addresses below BASE_ADDR wrap to huge offsets, so one compare covers both ends.
   assign w_off = {Addr, 2'b00} - BASE_ADDR;
   assign w_hit = (w_off < 32'(16 * NUM_CH));
   assign w_ch  = w_off[6:4];
   assign w_reg = w_off[3:2];

   for (genvar g = 0; g < NUM_CH; g++) begin : gCh
      state_t           r_state, w_next;
      logic             r_en, r_im, r_pend;
      logic [1:0]       r_mode;
      logic [CNT_W-1:0] r_preset, r_count;
      logic             w_sel, w_wrCtrl, w_wrPreset, w_wrStatus, w_abort, w_tick;
      logic             w_load, w_dec, w_zero, w_setPend, w_hwClrEn;
      logic [15:0]      w_prescaleRd;
      logic [31:0]      w_rd;

      assign w_sel      = WE && w_hit && (w_ch == 3'(g));
      assign w_wrCtrl   = w_sel && (w_reg == 2'd0);
      assign w_wrPreset = w_sel && (w_reg == 2'd1);
      assign w_wrStatus = w_sel && (w_reg == 2'd3);
      // A CTRL write clearing EN stops a running channel on the very next cycle.
      assign w_abort    = w_wrCtrl && !Din[0];

`ifdef TC_PRESCALE_EN
      logic [15:0] r_prescale, r_psCnt;

      assign w_tick       = (r_psCnt >= r_prescale);
      assign w_prescaleRd = r_prescale;

      always_ff @(posedge clk) begin
         if (reset) begin
            r_prescale <= '0;
            r_psCnt    <= '0;
         end else begin
            if (w_wrStatus) r_prescale <= Din[31:16];
            if (r_state == S_LOAD) r_psCnt <= '0;
            else if (r_state == S_CNT) r_psCnt <= w_tick ? 16'd0 : r_psCnt + 16'd1;
         end
      end
`else
      assign w_tick       = 1'b1;
      assign w_prescaleRd = '0;
`endif

      always_ff @(posedge clk) begin
         if (reset) r_state <= S_IDLE;
         else       r_state <= w_next;
      end

      always_comb begin
         w_next = r_state;
         case (r_state)
            S_IDLE: if (r_en) w_next = S_LOAD;
            S_LOAD: w_next = (!r_en || w_abort) ? S_IDLE : S_CNT;
            S_CNT: begin
               if (!r_en || w_abort)           w_next = S_IDLE;
               else if (r_count <= CNT_W'(1))  w_next = S_INT;
            end
            S_INT:  w_next = (r_mode == 2'b01) ? S_LOAD : S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end

      always_comb begin
         w_load    = (r_state == S_LOAD) && r_en && !w_abort;
         w_dec     = (r_state == S_CNT) && r_en && !w_abort && (r_count > CNT_W'(1)) && w_tick;
         w_zero    = (r_state == S_CNT) && r_en && !w_abort && (r_count <= CNT_W'(1));
         w_setPend = (r_state == S_INT);
         w_hwClrEn = (r_state == S_INT) && (r_mode != 2'b01);
      end

      // Software CTRL writes beat the one-shot EN clear; a hardware PEND set beats W1C.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_en     <= 1'b0;
            r_mode   <= 2'b00;
            r_im     <= 1'b0;
            r_preset <= '0;
            r_count  <= '0;
            r_pend   <= 1'b0;
         end else begin
            if (w_wrCtrl) begin
               r_en   <= Din[0];
               r_mode <= Din[2:1];
               r_im   <= Din[3];
            end else if (w_hwClrEn) begin
               r_en <= 1'b0;
            end
            if (w_wrPreset) r_preset <= Din[CNT_W-1:0];
            if (w_load)      r_count <= r_preset;
            else if (w_dec)  r_count <= r_count - CNT_W'(1);
            else if (w_zero) r_count <= '0;
            if (w_setPend)                  r_pend <= 1'b1;
            else if (w_wrStatus && Din[0])  r_pend <= 1'b0;
         end
      end

      always_comb begin
         w_rd = '0;
         case (w_reg)
            2'd0: w_rd = {28'd0, r_im, r_mode, r_en};
            2'd1: w_rd = 32'(r_preset);
            2'd2: w_rd = 32'(r_count);
            default: w_rd = {w_prescaleRd, 15'd0, r_pend};
         endcase
      end

      assign w_chRd[g] = w_rd;
      assign IRQ[g]    = r_pend & r_im;
   end

   always_comb begin
      Dout = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_hit && (w_ch == 3'(i))) Dout = w_chRd[i];
      end
   end

endmodule

// File: tb/tb_tc_bank.sv
// tb_tc_bank: directed and randomized checks of tc_bank against a closed-form timing model.
// Cycle 0 of a channel is the first cycle in which its CTRL register shows EN=1.
module tb_tc_bank;

   localparam int          NUM_CH = 2;
   localparam logic [31:0] BASE   = 32'h0000_7F00;

   logic              clk = 1'b0;
   logic              reset;
   logic [29:0]       Addr;
   logic              WE;
   logic [31:0]       Din;
   logic [31:0]       Dout;
   logic [NUM_CH-1:0] IRQ;

   int checks = 0;
   int errors = 0;

   tc_bank #(.NUM_CH(NUM_CH), .BASE_ADDR(BASE), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout), .IRQ(IRQ)
   );

   always #5 clk = ~clk;

   // Expected COUNT c cycles after enable, derived from load/decrement/expire timing.
   function automatic int expCount(int c, int n, bit autoRel);
      int nn, k;
      nn = (n < 1) ? 1 : n;
      if (!autoRel) return (c >= 2 && c <= nn + 1) ? n - (c - 2) : 0;
      if (c < 1) return 0;
      k = (c - 1) % (nn + 2);
      return (k >= 1 && k <= nn) ? n - (k - 1) : 0;
   endfunction

   function automatic bit expPend(int c, int n);
      int nn;
      nn = (n < 1) ? 1 : n;
      return c >= nn + 3;
   endfunction

   function automatic logic [29:0] wordAddr(int ch, int off);
      logic [31:0] b;
      b = BASE + 32'(16 * ch + 4 * off);
      return b[31:2];
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(int ch, int off, logic [31:0] data);
      Addr = wordAddr(ch, off);
      Din  = data;
      WE   = 1'b1;
      tick();
      WE   = 1'b0;
      Din  = '0;
   endtask

   task automatic readCheck(string tag, int ch, int off, logic [31:0] exp);
      Addr = wordAddr(ch, off);
      #1;
      checkOutput(tag, Dout, exp);
   endtask

   task automatic resetDut();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int n0, n1, m0, m1, im0, im1, ch, c1, exp;
      bit a0, a1;
      reset = 1'b1;
      Addr  = '0;
      WE    = 1'b0;
      Din   = '0;
      @(negedge clk);
      resetDut();

      // Reset state and a read just past the window.
      for (int c = 0; c < 2; c++)
         for (int r = 0; r < 4; r++)
            readCheck($sformatf("reset ch%0d reg%0d", c, r), c, r, 32'h0);
      checkOutput("reset irq", 32'(IRQ), 32'h0);
      readCheck("reset miss", NUM_CH, 0, 32'h0);

      // Ch0 one-shot, PRESET=5, IRQ at cycle 8.
      applyStimulus(0, 1, 32'd5);
      applyStimulus(0, 0, 32'h9);
      for (int c = 0; c <= 8; c++) begin
         readCheck($sformatf("oneshot cnt c%0d", c), 0, 2, 32'(expCount(c, 5, 1'b0)));
         checkOutput($sformatf("oneshot irq c%0d", c), 32'(IRQ[0]), 32'(c >= 8));
         if (c < 8) tick();
      end
      readCheck("oneshot ctrl", 0, 0, 32'h8);
      applyStimulus(0, 3, 32'h1);
      checkOutput("oneshot w1c irq", 32'(IRQ[0]), 32'h0);
      readCheck("oneshot w1c status", 0, 3, 32'h0);

      // Ch1 auto-reload, PRESET=3, PEND at 6/11/16 with clears landing at 9 and 12.
      applyStimulus(1, 1, 32'd3);
      applyStimulus(1, 0, 32'hB);
      for (int c = 0; c <= 16; c++) begin
         checkOutput($sformatf("reload irq c%0d", c), 32'(IRQ[1]),
                     32'((c >= 6 && c <= 8) || c == 11 || c == 16));
         readCheck($sformatf("reload cnt c%0d", c), 1, 2, 32'(expCount(c, 3, 1'b1)));
         if (c == 8 || c == 11) applyStimulus(1, 3, 32'h1);
         else tick();
      end
      applyStimulus(1, 0, 32'h0);

      // Masked expiry on ch0 while ch1 keeps counting.
      resetDut();
      applyStimulus(1, 1, 32'd10);
      applyStimulus(1, 0, 32'hB);
      applyStimulus(0, 1, 32'd2);
      applyStimulus(0, 0, 32'h1);
      repeat (5) tick();
      readCheck("mask status", 0, 3, 32'h1);
      checkOutput("mask irq", 32'(IRQ), 32'h0);
      readCheck("mask ch1 cnt c7", 1, 2, 32'd5);
      tick();
      readCheck("mask ch1 cnt c8", 1, 2, 32'd4);
      readCheck("mask ch0 ctrl", 0, 0, 32'h0);

      // Collisions in the INT cycle (cycle 4 for PRESET=2).
      resetDut();
      applyStimulus(0, 1, 32'd2);
      applyStimulus(0, 0, 32'h9);
      repeat (4) tick();
      applyStimulus(0, 3, 32'h1);
      readCheck("coll w1c status", 0, 3, 32'h1);
      checkOutput("coll w1c irq", 32'(IRQ[0]), 32'h1);
      applyStimulus(0, 3, 32'h1);
      checkOutput("coll cleared irq", 32'(IRQ[0]), 32'h0);
      applyStimulus(0, 0, 32'h9);
      repeat (4) tick();
      applyStimulus(0, 0, 32'h3);
      readCheck("coll ctrl", 0, 0, 32'h3);
      readCheck("coll ctrl status", 0, 3, 32'h1);
      tick();
      tick();
      readCheck("coll reload cnt", 0, 2, 32'd2);

      // Ignored writes, unused bits and out-of-window accesses.
      resetDut();
      applyStimulus(0, 2, 32'h55);
      readCheck("count ro", 0, 2, 32'h0);
      applyStimulus(0, 0, 32'hFFFF_FFF6);
      readCheck("ctrl bits", 0, 0, 32'h6);
      applyStimulus(0, 3, 32'hFFFF_0000);
      readCheck("status upper", 0, 3, 32'h0);
      applyStimulus(NUM_CH, 1, 32'hAB);
      applyStimulus(-1, 1, 32'hCD);
      readCheck("miss wr ch0", 0, 1, 32'h0);
      readCheck("miss wr ch1", 1, 1, 32'h0);
      readCheck("miss rd hi", NUM_CH, 1, 32'h0);
      readCheck("miss rd lo", -1, 1, 32'h0);

      // Randomized trials: both channels started one cycle apart.
      for (int t = 0; t < 6; t++) begin
         resetDut();
         n0  = $urandom_range(0, 9);
         n1  = $urandom_range(0, 9);
         m0  = $urandom_range(0, 3);
         m1  = $urandom_range(0, 3);
         im0 = $urandom_range(0, 1);
         im1 = $urandom_range(0, 1);
         a0  = (m0 == 1);
         a1  = (m1 == 1);
         applyStimulus(0, 1, 32'(n0));
         applyStimulus(1, 1, 32'(n1));
         applyStimulus(0, 0, 32'(im0 * 8 + m0 * 2 + 1));
         applyStimulus(1, 0, 32'(im1 * 8 + m1 * 2 + 1));
         for (int c = 1; c <= 30; c++) begin
            c1  = c - 1;
            exp = (im1 * int'(expPend(c1, n1))) * 2 + im0 * int'(expPend(c, n0));
            checkOutput($sformatf("rnd%0d irq c%0d", t, c), 32'(IRQ), 32'(exp));
            ch = c % 2;
            if (ch == 0) readCheck($sformatf("rnd%0d cnt0 c%0d", t, c), 0, 2, 32'(expCount(c, n0, a0)));
            else         readCheck($sformatf("rnd%0d cnt1 c%0d", t, c), 1, 2, 32'(expCount(c1, n1, a1)));
            tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
